// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shift encodings and output-stage states shared by the shift arbiter
package shift_arb_pkg;
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;
  typedef enum logic {
    SHIFT_LOGIC = 1'b0,
    SHIFT_ARITH = 1'b1
  } type_e;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/shift_arb_if.sv
// shift_arb_if: requester valid/ready bundle plus the single result channel
interface shift_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int SW = $clog2(WIDTH);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*SW-1:0]    req_amt;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ-1:0]       req_type;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [IW-1:0]         resp_src;
  modport master (
    output req_valid, req_data, req_amt, req_dir, req_type, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_src
  );
  modport slave (
    input  req_valid, req_data, req_amt, req_dir, req_type, resp_ready,
    output req_ready, resp_valid, resp_data, resp_src
  );
endinterface

// File: rtl/barrel_shifter.sv
// barrel_shifter: log-stage shifter; left shifts reuse the right-shift stages on bit-reversed data
module barrel_shifter
  import shift_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SW-1:0]    amt_i,
  input  dir_e             dir_i,
  input  type_e            type_i,
  output logic [WIDTH-1:0] data_o
);
  logic             fill;
  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] st [SW+1];
  for (genvar b = 0; b < WIDTH; b++) begin : g_rev
    assign rev_in[b]  = data_i[WIDTH-1-b];
    assign rev_out[b] = st[SW][WIDTH-1-b];
  end
  assign fill  = dir_i == DIR_RIGHT && type_i == SHIFT_ARITH && data_i[WIDTH-1];
  assign st[0] = dir_i == DIR_LEFT ? rev_in : data_i;
  for (genvar s = 0; s < SW; s++) begin : g_stage
    assign st[s+1] = amt_i[s] ? {{(2**s){fill}}, st[s][WIDTH-1:2**s]} : st[s];
  end
  assign data_o = dir_i == DIR_LEFT ? rev_out : st[SW];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr with wrap
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  int j;
  // walk offsets from farthest to nearest so the nearest requester at or after ptr wins
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (en_i && req_i[j]) begin
        grant_o = '0;
        grant_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/shift_arb.sv
// shift_arb: round-robin sharing of one barrel shifter with a single registered result stage
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic        clk,
  input logic        rst,
  shift_arb_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int IW = $clog2(NREQ);
  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [IW-1:0]    src_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [IW-1:0]    gidx;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] shifted;
  logic             can_accept;
  logic             xfer;
  assign can_accept = state_q == EMPTY || bus.resp_ready;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i  (bus.req_valid),
    .ptr_i  (ptr_q),
    .en_i   (can_accept && !rst),
    .grant_o(grant),
    .idx_o  (gidx)
  );
  barrel_shifter #(.WIDTH(WIDTH)) u_shf (
    .data_i(bus.req_data[gidx*WIDTH +: WIDTH]),
    .amt_i (bus.req_amt[gidx*SW +: SW]),
    .dir_i (dir_e'(bus.req_dir[gidx])),
    .type_i(type_e'(bus.req_type[gidx])),
    .data_o(shifted)
  );
  assign xfer           = |grant;
  assign ptr_d          = gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1;
  assign bus.req_ready  = grant;
  assign bus.resp_valid = state_q == FULL;
  assign bus.resp_data  = data_q;
  assign bus.resp_src   = src_q;
  // output stage: load on transfer, drain when consumed, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else if (xfer) begin
      state_q <= FULL;
      data_q  <= shifted;
      src_q   <= gidx;
      ptr_q   <= ptr_d;
    end else if (bus.resp_ready) begin
      state_q <= EMPTY;
    end
  end
endmodule

// File: doc/shift_arb.md
Name: shift_arb

Overview:
- Shares one combinational barrel shifter datapath between NREQ requesters.
- Round-robin arbitration, valid/ready handshake on every requester and on the single result channel.
- One registered output stage: 1-cycle latency, full throughput of one shift per cycle.
- Sits between issue logic of several units (ALU lanes, address gen) and one shifter instance.

Parameters:
WIDTH, 8, data width in bits; power of two, at least 4
NREQ, 4, number of requesters; at least 2
SW, $clog2(WIDTH), shift-amount width (derived, not overridden)
IW, $clog2(NREQ), requester-index width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_data  in  NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
req_amt  in  NREQ*SW  shift amounts, requester i at [i*SW +: SW]
req_dir  in  NREQ  0 left, 1 right
req_type  in  NREQ  0 logical, 1 arithmetic (right shifts only)
resp_valid  out  1  result valid
resp_ready  in  1  downstream accept
resp_data  out  WIDTH  shifted result
resp_src  out  IW  index of the requester that produced resp_data

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous, active-high.
- Reset values: resp_valid=0, resp_data=0, resp_src=0, round-robin pointer ptr=0. Combinational req_ready reads 0 while rst is asserted.
- Accept condition: can_accept = !resp_valid || resp_ready.
- Grant selection: grant is the first index with req_valid set, searching ptr, ptr+1, … NREQ-1, 0, … wrapping.
- Grant is purely combinational from req_valid and ptr. req_ready[i] = can_accept && grant[i].
- req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Transfer occurs on a clock edge where req_valid[g] && req_ready[g]. On that edge:
  - resp_data <= shifter(req_data[g], req_amt[g], req_dir[g], req_type[g])
  - resp_src <= g
  - resp_valid <= 1
  - ptr <= (g+1) mod NREQ
- ptr is unchanged in cycles with no transfer.
- Output register states:
  - EMPTY (resp_valid=0): goes to FULL on a transfer.
  - FULL (resp_valid=1):
    - resp_ready=1 with a transfer: reload in the same cycle and stay FULL (back-to-back, no bubble).
    - resp_ready=1 with no transfer: go to EMPTY.
    - resp_ready=0: hold resp_data and resp_src stable, and drive all req_ready to 0.
- Shift rules:
  - Amount 0 passes data through unchanged.
  - Left shift fills with 0 and ignores req_type.
  - Logical right fills with 0.
  - Arithmetic right fills with the operand MSB.
  - Maximum amount is WIDTH-1; there is no wrap or saturation.
- Fairness: a requester that holds req_valid continuously is granted within NREQ transfers.
- Requester stability: request fields must stay stable while req_valid=1 and req_ready=0. The block does not latch unaccepted requests.
- Reset mid-operation: a pending result is discarded, resp_valid drops asynchronously, and ptr returns to 0.
- After rst deasserts, the first grant goes to the lowest valid index.
- Latency: accept edge to resp_valid is 1 cycle. There are no other internal pipeline stages.

Decomposition:
- Shared package holds the shift-direction and shift-type encodings (DIR_LEFT=0, DIR_RIGHT=1, SHIFT_LOGIC=0, SHIFT_ARITH=1).
- Sub-module rr_arbiter (parameter N): inputs req, ptr and enable; output one-hot grant and its encoded index.
- Datapath: one instance of the team's existing combinational barrel shifter with WIDTH passed through, fed by the muxed granted fields.
- Pointer update and output register stay in shift_arb.

Test Plan:
- Use WIDTH=8, NREQ=4 for all scenarios.
- Single left shift: req0 data=0x96, amt=3, dir=0, resp_ready=1 -> next cycle resp_valid=1, resp_data=0xB0, resp_src=0; req_ready=4'b0001 in the accept cycle.
- Right shift types: req2 data=0x96, amt=2, dir=1.
  - type=1 -> resp_data=0xE5.
  - type=0 -> resp_data=0x25.
  - data=0x80, amt=7, type=1 -> resp_data=0xFF.
  - amt=0 -> resp_data=0x96.
- Round robin: all four req_valid held high, resp_ready=1 -> resp_src sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Round robin with gaps: only req1 and req3 valid -> resp_src alternates 1,3,1,3.
- Backpressure: result pending, resp_ready=0 for 3 cycles -> resp_data and resp_src stable, req_ready=0 throughout. Raise resp_ready -> next grant loads in the same cycle.
- Reset mid-operation: assert rst asynchronously while resp_valid=1 and ptr=2 -> resp_valid=0 immediately. After release, with all requests valid, the first resp_src=0.
